// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blank mask.
// One BIN_W-cycle conversion per accepted START; outputs update only on DONE.
module bin2bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             FPGA_CLK,
    input  logic             FPGA_RST_N,
    input  logic             START,
    input  logic [BIN_W-1:0] BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      BCD,
    output logic [3:0]       BLANK,
    output logic             OVF
);

    localparam int               CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [BIN_W-1:0]    scr_q, scr_d, scr_sh;
    logic [15:0]         acc_q, acc_d, acc_adj, acc_sh;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic                done_d;
    logic                over;
    logic [3:0]          blank_sh;
    logic [16+BIN_W-1:0] cat_sh;

    assign over = (BIN > MAX_B);

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        cat_sh = {acc_adj, scr_q} << 1;
        acc_sh = cat_sh[16+BIN_W-1 -: 16];
        scr_sh = cat_sh[BIN_W-1:0];
    end

    always_comb begin
        blank_sh    = 4'b0000;
        blank_sh[3] = (acc_sh[15:12] == 4'd0);
        blank_sh[2] = blank_sh[3] & (acc_sh[11:8] == 4'd0);
        blank_sh[1] = blank_sh[2] & (acc_sh[7:4] == 4'd0);
    end

    always_comb begin
        state_d    = state_q;
        scr_d      = scr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    scr_d      = over ? MAX_B : BIN;
                    acc_d      = 16'h0000;
                    cnt_d      = CNT_N;
                    ovf_pend_d = over;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                scr_d = scr_sh;
                cnt_d = cnt_q - CNT_1;
                if (cnt_q == CNT_1) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            state_q    <= IDLE;
            scr_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scr_q      <= scr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    // Result registers only load on the final shift, so no partial value escapes
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            DONE  <= 1'b0;
            BCD   <= 16'h0000;
            BLANK <= 4'b1110;
            OVF   <= 1'b0;
        end else begin
            DONE <= done_d;
            if (done_d) begin
                BCD   <= acc_sh;
                BLANK <= blank_sh;
                OVF   <= ovf_pend_q;
            end
        end
    end

    assign BUSY = (state_q == SHIFT);

endmodule
